// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline hazard/flush controller.
// State encoding, parameter defaults and control-bundle type.
package pipeline_control_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_MWAIT = 2'd2;

  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int MEM_TIMEOUT_DEF  = 255;
  localparam int CNT_W            = 16;

  typedef struct packed {
    logic if_stall;
    logic id1_stall;
    logic id2_stall;
    logic ex_stall;
    logic me_stall;
    logic id_clear;
    logic ex1_clear;
    logic ex2_clear;
    logic me2_clear;
    logic wb_clear;
    logic id_split;
  } ctl_t;

  function automatic ctl_t ctl_idle();
    return '0;
  endfunction

endpackage

// File: rtl/pipeline_control_t_sat.sv
// Saturating up-counter with synchronous clear.
// Reset and clear both return it to zero.
module sat_counter_t
  import pipeline_control_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_control_t.sv
// Dual-issue pipeline stall/flush controller.
// Memory wait dominates redirects, which dominate ID hazards.
module pipeline_control_t
  import pipeline_control_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ACT,
  input  logic             me_busy,
  input  logic             ex_redirect,
  input  logic             redirect_lane,
  input  logic             id_hazard,
  input  logic             pair_conflict,
  output logic             if_stall,
  output logic             id1_stall,
  output logic             id2_stall,
  output logic             ex_stall,
  output logic             me_stall,
  output logic             id_clear,
  output logic             ex1_clear,
  output logic             ex2_clear,
  output logic             me2_clear,
  output logic             wb_clear,
  output logic             id_split,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       flush_cnt;
  logic             ret_flush;
  logic [CNT_W-1:0] wait_cnt;

  logic [1:0] state_nx;
  logic [1:0] flush_nx;
  logic       ret_nx;
  ctl_t       ctl;

  always_comb begin
    ctl = ctl_idle();
    if (ACT) begin
      if (me_busy) begin
        ctl.if_stall  = 1'b1;
        ctl.id1_stall = 1'b1;
        ctl.id2_stall = 1'b1;
        ctl.ex_stall  = 1'b1;
        ctl.me_stall  = 1'b1;
        ctl.wb_clear  = 1'b1;
      end else if (ex_redirect) begin
        ctl.id_clear  = 1'b1;
        ctl.ex1_clear = 1'b1;
        ctl.ex2_clear = 1'b1;
        ctl.me2_clear = ~redirect_lane;
      end else if (state == ST_FLUSH) begin
        ctl.id_clear  = 1'b1;
        ctl.ex1_clear = 1'b1;
        ctl.ex2_clear = 1'b1;
      end else if (id_hazard) begin
        ctl.if_stall  = 1'b1;
        ctl.id1_stall = 1'b1;
        ctl.id2_stall = 1'b1;
        ctl.ex1_clear = 1'b1;
        ctl.ex2_clear = 1'b1;
      end else if (pair_conflict) begin
        ctl.id_split  = 1'b1;
        ctl.if_stall  = 1'b1;
        ctl.ex2_clear = 1'b1;
      end
    end
  end

  // Flush counter freezes across a memory wait and resumes afterwards.
  always_comb begin
    state_nx = state;
    flush_nx = flush_cnt;
    ret_nx   = ret_flush;
    if (me_busy) begin
      state_nx = ST_MWAIT;
      if (state == ST_FLUSH) ret_nx = 1'b1;
    end else if (ex_redirect) begin
      state_nx = ST_FLUSH;
      flush_nx = FLUSH_LOAD;
      ret_nx   = 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_MWAIT): begin
          state_nx = ret_flush ? ST_FLUSH : ST_RUN;
          ret_nx   = 1'b0;
        end
        (state == ST_FLUSH): begin
          flush_nx = flush_cnt - 2'd1;
          if (flush_cnt <= 2'd1) state_nx = ST_RUN;
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_RUN;
      flush_cnt   <= '0;
      ret_flush   <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (ACT) begin
      state     <= state_nx;
      flush_cnt <= flush_nx;
      ret_flush <= ret_nx;
      if (me_busy && (wait_cnt >= TO_LAST)) mem_timeout <= 1'b1;
    end
  end

  sat_counter_t #(.W(CNT_W)) u_wait (
    .clk   (CLK),
    .rst   (RST),
    .clr   (ACT & ~me_busy),
    .en    (ACT & me_busy),
    .count (wait_cnt)
  );

  sat_counter_t #(.W(CNT_W)) u_stall (
    .clk   (CLK),
    .rst   (RST),
    .clr   (1'b0),
    .en    (ACT & ctl.if_stall),
    .count (stall_cnt)
  );

  assign if_stall  = ctl.if_stall;
  assign id1_stall = ctl.id1_stall;
  assign id2_stall = ctl.id2_stall;
  assign ex_stall  = ctl.ex_stall;
  assign me_stall  = ctl.me_stall;
  assign id_clear  = ctl.id_clear;
  assign ex1_clear = ctl.ex1_clear;
  assign ex2_clear = ctl.ex2_clear;
  assign me2_clear = ctl.me2_clear;
  assign wb_clear  = ctl.wb_clear;
  assign id_split  = ctl.id_split;

endmodule

// File: tb/tb_pipeline_control_t.sv
// Scoreboard bench for pipeline_control_t.
// Driver pushes model expectations; monitor pops and compares.
module tb_pipeline_control_t;

  localparam int FC = 2;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst, act, busy, redir, lane, haz, pair;
  logic        if_s, id1_s, id2_s, ex_s, me_s;
  logic        id_c, ex1_c, ex2_c, me2_c, wb_c, split;
  logic [1:0]  st;
  logic [15:0] scnt;
  logic        mto;

  always #5 clk = ~clk;

  pipeline_control_t #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .CLK(clk), .RST(rst), .ACT(act),
    .me_busy(busy), .ex_redirect(redir),
    .redirect_lane(lane), .id_hazard(haz),
    .pair_conflict(pair),
    .if_stall(if_s), .id1_stall(id1_s),
    .id2_stall(id2_s), .ex_stall(ex_s),
    .me_stall(me_s), .id_clear(id_c),
    .ex1_clear(ex1_c), .ex2_clear(ex2_c),
    .me2_clear(me2_c), .wb_clear(wb_c),
    .id_split(split), .state(st),
    .stall_cnt(scnt), .mem_timeout(mto)
  );

  typedef struct packed {
    logic [10:0] ctl;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 0;

  // Reference model: abstract counters in plain integers.
  int m_state = 0;
  int m_left  = 0;
  int m_ret   = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_to    = 0;

  task automatic model_reset();
    m_state = 0; m_left = 0; m_ret = 0;
    m_wait = 0; m_stall = 0; m_to = 0;
  endtask

  task automatic cyc(input logic r, input logic a,
                     input logic b, input logic x,
                     input logic l, input logic h,
                     input logic p);
    exp_t e;
    bit s_if, s_id, s_ex, s_me, c_id, c_ex1, c_ex2;
    bit c_me2, c_wb, sp;
    @(negedge clk);
    rst = r; act = a; busy = b; redir = x;
    lane = l; haz = h; pair = p;
    {s_if, s_id, s_ex, s_me} = '0;
    {c_id, c_ex1, c_ex2, c_me2, c_wb, sp} = '0;
    if (a) begin
      if (b) begin
        s_if = 1; s_id = 1; s_ex = 1; s_me = 1; c_wb = 1;
      end else if (x) begin
        c_id = 1; c_ex1 = 1; c_ex2 = 1; c_me2 = !l;
      end else if (m_state == 1) begin
        c_id = 1; c_ex1 = 1; c_ex2 = 1;
      end else if (h) begin
        s_if = 1; s_id = 1; c_ex1 = 1; c_ex2 = 1;
      end else if (p) begin
        sp = 1; s_if = 1; c_ex2 = 1;
      end
    end
    e.ctl = {s_if, s_id, s_id, s_ex, s_me, c_id,
             c_ex1, c_ex2, c_me2, c_wb, sp};
    e.st  = 2'(m_state);
    e.cnt = 16'(m_stall);
    e.to  = m_to[0];
    q.push_back(e);
    if (r) begin
      model_reset();
    end else if (a) begin
      if (s_if && m_stall < 65535) m_stall++;
      if (b) begin
        if (m_wait < 65535) m_wait++;
        if (m_wait >= MT) m_to = 1;
        if (m_state == 1) m_ret = 1;
        m_state = 2;
      end else begin
        m_wait = 0;
        if (x) begin
          m_state = 1; m_left = FC; m_ret = 0;
        end else if (m_state == 2) begin
          m_state = m_ret ? 1 : 0; m_ret = 0;
        end else if (m_state == 1) begin
          m_left--;
          if (m_left == 0) m_state = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        got.ctl = {if_s, id1_s, id2_s, ex_s, me_s, id_c,
                   ex1_c, ex2_c, me2_c, wb_c, split};
        got.st  = st;
        got.cnt = scnt;
        got.to  = mto;
        n_tests++;
        if (got !== e) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL cyc t=%0t ctl/st/cnt/to got %b/%0d/%h/%b want %b/%0d/%h/%b",
                     $time, got.ctl, got.st, got.cnt, got.to,
                     e.ctl, e.st, e.cnt, e.to);
        end
      end
    end
  end

  initial begin : driver
    rst = 1; act = 0; busy = 0; redir = 0;
    lane = 0; haz = 0; pair = 0;
    model_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(5);
    // hazard, split, redirect with hazard during flush
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 1, 0);
    idle(2);
    // memory wait inside a flush, timeout, lane1 redirect
    cyc(0, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 1, 1, 0, 1, 1);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 1, 1);
    idle(2);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0),
          1'($urandom), 1'($urandom), 1'($urandom));
    // saturation of stall_cnt with a freeze midway
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    idle(2);
    repeat (3) @(negedge clk);
    #4;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
